// File: rtl/hdmi_island_scheduler.sv
// rtl/hdmi_island_scheduler.sv - HDMI data island scheduler: preamble/guard/packet sequencing with round-robin packet arbitration
// Define ISLAND_AVI_PRIORITY_EN to give source 0 (AVI InfoFrame) strict priority over the round-robin.
module hdmi_island_scheduler #(
    parameter int NUM_REQ  = 3,
    parameter int LEAD     = 4,
    parameter int MAX_PKTS = 2,
    parameter int HBLANK   = 160
) (
    input  logic               clock,
    input  logic               rstn,
    input  logic               de,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic [1:0]         packet_sel,
    output logic               packet_start,
    output logic               data_preamble,
    output logic               data_guard,
    output logic               data_period,
    output logic               island_abort
);

    localparam int CW = ($clog2(LEAD + 1) > 6) ? $clog2(LEAD + 1) : 6;
    localparam int PW = $clog2(MAX_PKTS + 1);

    if (LEAD + 8 + 2 + 32 * MAX_PKTS + 2 + 10 > HBLANK) begin : g_hblank_check
        $error("hdmi_island_scheduler: island does not fit in HBLANK");
    end
    if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_num_req_check
        $error("hdmi_island_scheduler: NUM_REQ must be 2..4");
    end

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEAD, ST_PREAMBLE, ST_GUARD_L, ST_DATA, ST_GUARD_T
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      pkt_q, pkt_d;
    logic [1:0]         sel_q, sel_d;
    logic [1:0]         ptr_q, ptr_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic               abort_q, abort_d;
    logic               de_q, de_prev_q;

    logic               fall, rise, found, first_beat;
    logic [1:0]         pick_idx, ptr_adv;
    logic [2:0]         pick;
    logic [NUM_REQ-1:0] cand;

    function automatic logic [2:0] arb_pick(input logic [NUM_REQ-1:0] c, input logic [1:0] start);
        logic [2:0]         res;
        logic [NUM_REQ-1:0] rot;
        int                 idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(start) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            rot = c >> idx;
            if (rot[0]) res = {1'b1, idx[1:0]};
        end
        return res;
    endfunction

    function automatic logic [2:0] grant_pick(input logic [NUM_REQ-1:0] c, input logic [1:0] start);
`ifdef ISLAND_AVI_PRIORITY_EN
        if (c[0]) return 3'b100;
        return arb_pick(c & ~NUM_REQ'(1), start);
`else
        return arb_pick(c, start);
`endif
    endfunction

    // de is registered twice so edges are judged on two settled samples
    assign fall = de_prev_q & ~de_q;
    assign rise = ~de_prev_q & de_q;

    // The first grant of an island ignores the mask, which still holds the previous island
    assign cand     = (state_q == ST_LEAD) ? req : (req & ~mask_q);
    assign pick     = grant_pick(cand, ptr_q);
    assign found    = pick[2];
    assign pick_idx = pick[1:0];

    always_comb begin
        ptr_adv = (pick_idx == 2'(NUM_REQ - 1)) ? 2'd0 : pick_idx + 2'd1;
`ifdef ISLAND_AVI_PRIORITY_EN
        if (pick_idx == 2'd0) ptr_adv = ptr_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        pkt_d   = pkt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        mask_d  = mask_q;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (fall) state_d = ST_LEAD;
            end
            ST_LEAD: begin
                if (rise) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(LEAD - 1)) begin
                    cnt_d   = '0;
                    state_d = found ? ST_PREAMBLE : ST_IDLE;
                    if (found) begin
                        sel_d  = pick_idx;
                        ptr_d  = ptr_adv;
                        mask_d = NUM_REQ'(1) << pick_idx;
                        pkt_d  = PW'(1);
                    end
                end
            end
            default: begin
                if (rise) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    abort_d = 1'b1;
                end else begin
                    case (state_q)
                        ST_PREAMBLE: if (cnt_q == CW'(7)) begin
                            state_d = ST_GUARD_L;
                            cnt_d   = '0;
                        end
                        ST_GUARD_L: if (cnt_q == CW'(1)) begin
                            state_d = ST_DATA;
                            cnt_d   = '0;
                        end
                        ST_DATA: if (cnt_q == CW'(31)) begin
                            cnt_d = '0;
                            if (found && pkt_q < PW'(MAX_PKTS)) begin
                                sel_d  = pick_idx;
                                ptr_d  = ptr_adv;
                                mask_d = mask_q | (NUM_REQ'(1) << pick_idx);
                                pkt_d  = pkt_q + PW'(1);
                            end else begin
                                state_d = ST_GUARD_T;
                            end
                        end
                        ST_GUARD_T: if (cnt_q == CW'(1)) begin
                            state_d = ST_IDLE;
                            cnt_d   = '0;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pkt_q     <= '0;
            sel_q     <= '0;
            ptr_q     <= '0;
            mask_q    <= '0;
            abort_q   <= 1'b0;
            de_q      <= 1'b0;
            de_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pkt_q     <= pkt_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            mask_q    <= mask_d;
            abort_q   <= abort_d;
            de_q      <= de;
            de_prev_q <= de_q;
        end
    end

    // A packet whose first beat coincides with the abort is never acknowledged
    assign first_beat    = (state_q == ST_DATA) && (cnt_q == '0) && !rise;
    assign packet_start  = first_beat;
    assign ack           = first_beat ? (NUM_REQ'(1) << sel_q) : '0;
    assign packet_sel    = sel_q;
    assign data_preamble = (state_q == ST_PREAMBLE);
    assign data_guard    = (state_q == ST_GUARD_L) || (state_q == ST_GUARD_T);
    assign data_period   = (state_q == ST_DATA);
    assign island_abort  = abort_q;

endmodule

// File: tb/tb_hdmi_island_scheduler.sv
// tb/tb_hdmi_island_scheduler.sv - randomized line-by-line bench for hdmi_island_scheduler
module tb_hdmi_island_scheduler;

    localparam int N     = 3;
    localparam int LEADC = 4;
    localparam int MAXP  = 2;
    localparam int HB    = 160;
    localparam int P0    = LEADC + 1;
    localparam int G0    = P0 + 8;
    localparam int D0    = G0 + 2;

    logic         clock = 1'b0;
    logic         rstn, de;
    logic [N-1:0] req, ack;
    logic [1:0]   packet_sel;
    logic         packet_start, data_preamble, data_guard, data_period, island_abort;

    int errors = 0;
    int checks = 0;

    logic [N-1:0] pend;
    int           ptr_m;
    int           line_no;
    int           n_g;
    int           g[MAXP];
    int           bcut;
    int           rs_cyc;
    bit           aborted;

    always #5 clock = ~clock;

    hdmi_island_scheduler #(.NUM_REQ(N), .LEAD(LEADC), .MAX_PKTS(MAXP), .HBLANK(HB)) dut (
        .clock(clock), .rstn(rstn), .de(de), .req(req), .ack(ack),
        .packet_sel(packet_sel), .packet_start(packet_start),
        .data_preamble(data_preamble), .data_guard(data_guard),
        .data_period(data_period), .island_abort(island_abort)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observed(input bit raw_sel);
        logic [1:0] s;
        s = (raw_sel || data_period) ? packet_sel : 2'b00;
        return {22'd0, data_preamble, data_guard, data_period, packet_start, ack, s, island_abort};
    endfunction

    // Next source in rotation order starting at p; -1 when nobody is eligible
    function automatic int model_pick(input logic [N-1:0] avail, input int p);
        logic [N-1:0] sh;
        int           i;
`ifdef ISLAND_AVI_PRIORITY_EN
        if (avail[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            i  = (p + k) % N;
            sh = avail >> i;
`ifdef ISLAND_AVI_PRIORITY_EN
            if (i != 0 && sh[0]) return i;
`else
            if (sh[0]) return i;
`endif
        end
        return -1;
    endfunction

    function automatic logic [31:0] expect_at(input int k);
        logic         pre, gua, per, st, ab;
        logic [N-1:0] a;
        logic [1:0]   s;
        int           t0, j;
        pre = 0; gua = 0; per = 0; st = 0; ab = 0; a = '0; s = 2'b00;
        if (rs_cyc >= 0 && k > rs_cyc) return 32'd0;
        if (aborted && k == bcut + 1) ab = 1'b1;
        else if (aborted && k > bcut) return 32'd0;
        else if (n_g > 0) begin
            t0 = D0 + 32 * n_g;
            if (k >= P0 && k < G0) pre = 1'b1;
            else if (k >= G0 && k < D0) gua = 1'b1;
            else if (k >= D0 && k < t0) begin
                per = 1'b1;
                j   = (k - D0) / 32;
                s   = 2'(g[j]);
                if ((k - D0) % 32 == 0 && !(aborted && k == bcut)) begin
                    st = 1'b1;
                    a  = N'(1) << g[j];
                end
            end else if (k >= t0 && k < t0 + 2) gua = 1'b1;
        end
        return {22'd0, pre, gua, per, st, a, s, ab};
    endfunction

    // One line: de low for b cycles (blanking), then high for a cycles
    task automatic run_line(input logic [N-1:0] add, input int b, input int a, input bit do_rst);
        logic [N-1:0] avail, acked;
        int           p, pk, arb, endc, c;
        line_no++;
        pend   = pend | add;
        req    = pend;
        bcut   = b;
        rs_cyc = do_rst ? G0 : -1;
        n_g    = 0;
        avail  = pend;
        p      = ptr_m;
        for (int j = 0; j < MAXP; j++) begin
            pk = model_pick(avail, p);
            if (pk < 0) break;
            arb = (j == 0) ? LEADC : D0 + 32 * j - 1;
            if (arb >= bcut) break;
            g[j]  = pk;
            n_g++;
            avail = avail & ~(N'(1) << pk);
`ifdef ISLAND_AVI_PRIORITY_EN
            if (pk != 0) p = (pk + 1) % N;
`else
            p = (pk + 1) % N;
`endif
        end
        ptr_m   = do_rst ? 0 : p;
        endc    = D0 + 32 * n_g + 2;
        aborted = (n_g > 0) && (bcut >= P0) && (bcut < endc);
        acked   = '0;
        for (int j = 0; j < n_g; j++) begin
            c = D0 + 32 * j;
            if (!(aborted && c >= bcut) && !(do_rst && c > rs_cyc)) acked = acked | (N'(1) << g[j]);
        end
        de = 1'b0;
        for (int k = 0; k < b + a; k++) begin
            @(negedge clock);
            check($sformatf("line%0d_cyc%0d", line_no, k), observed(1'b0), expect_at(k));
            if (do_rst && k == rs_cyc) begin
                rstn = 1'b0;
                #1;
                check($sformatf("line%0d_reset_outputs", line_no), observed(1'b1), 32'd0);
            end
            if (do_rst && k == rs_cyc + 1) rstn = 1'b1;
            de = (k + 1 >= b);
        end
        pend = pend & ~acked;
        req  = pend;
    endtask

    initial begin
        logic [N-1:0] add;
        int           b;
        rstn    = 1'b0;
        de      = 1'b1;
        req     = '0;
        pend    = '0;
        ptr_m   = 0;
        line_no = 0;
        repeat (3) @(negedge clock);
        check("reset_state", observed(1'b1), 32'd0);
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check("idle_after_reset", observed(1'b1), 32'd0);
        end
        run_line(3'b111, HB, 20, 1'b0);
        run_line(3'b011, HB, 20, 1'b0);
        run_line(3'b000, HB, 20, 1'b0);
        run_line(3'b000, HB, 20, 1'b0);
        run_line(3'b001, HB, 20, 1'b0);
        run_line(3'b111, D0 + 9, 20, 1'b0);
        run_line(3'b111, HB, 20, 1'b1);
        run_line(3'b000, HB, 20, 1'b0);
        repeat (30) begin
            add = 3'($urandom_range(0, 7));
            b   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 95)) : HB;
            run_line(add, b, int'($urandom_range(10, 30)), 1'b0);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
